// File: rtl/pes_traffic_pkg.sv
//==============================================================================
// Module : pes_traffic_pkg
// Brief  : Light encodings and sensor FSM state type shared by the pes_* blocks.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package pes_traffic_pkg;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        SERVING = 2'd2
    } sensor_state_t;

    // Only the exact green code counts; illegal codes read as not green.
    function automatic logic is_green(input logic [2:0] light);
        return (light == LIGHT_GRN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pes_debounce.sv
//==============================================================================
// Module : pes_debounce
// Brief  : Two-flop synchroniser followed by a run-length debounce counter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pes_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor_raw,
    output logic sensor_db
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic               r_db;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1 <= sensor_raw;
            r_s2 <= r_s1;
            // Any sample agreeing with the current level restarts the run.
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sensor_db = r_db;

endmodule

`default_nettype wire

// File: rtl/pes_vehicle_sensor.sv
//==============================================================================
// Module : pes_vehicle_sensor
// Brief  : Farm-road request generator for pes_traffic (debounce, arrivals,
//          request hold until green). Optional PES_SENSOR_STUCK_EN adds a
//          stuck-high detector that suppresses level re-requests.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module pes_vehicle_sensor
    import pes_traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int COUNT_W         = 8,
    parameter int STUCK_CYCLES    = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sensor_raw,
    input  logic [2:0]         light_farm,
    output logic               C,
    output logic               sensor_db,
    output logic [COUNT_W-1:0] veh_count,
    output logic               stuck_fault
);

    logic               w_db;
    logic               r_db_q;
    logic               w_arrival;
    logic               w_green;
    logic               w_stuck;
    logic               w_level_req;
    logic [COUNT_W-1:0] r_veh;
    logic               r_pend;
    sensor_state_t      r_state;

    pes_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk        (clk),
        .rst_n      (rst_n),
        .sensor_raw (sensor_raw),
        .sensor_db  (w_db)
    );

    assign w_arrival   = w_db & ~r_db_q;
    assign w_green     = is_green(light_farm);
    assign w_level_req = w_db & ~w_stuck;

`ifdef PES_SENSOR_STUCK_EN
    localparam int c_stuck_w = $clog2(STUCK_CYCLES + 1);
    localparam logic [c_stuck_w-1:0] c_stuck_max = c_stuck_w'(STUCK_CYCLES);

    logic [c_stuck_w-1:0] r_stuck_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck_cnt <= '0;
        end else if (!w_db) begin
            r_stuck_cnt <= '0;
        end else if (r_stuck_cnt != c_stuck_max) begin
            r_stuck_cnt <= r_stuck_cnt + 1'b1;
        end
    end

    assign w_stuck = (r_stuck_cnt == c_stuck_max);
`else
    assign w_stuck = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_q <= 1'b0;
            r_veh  <= '0;
        end else begin
            r_db_q <= w_db;
            if (w_arrival && (r_veh != '1)) begin
                r_veh <= r_veh + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pend  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arrival || w_level_req) begin
                        r_state <= PENDING;
                    end
                end
                PENDING: begin
                    if (w_green) begin
                        r_state <= SERVING;
                    end
                end
                SERVING: begin
                    // Vehicles seen during green re-request once green ends.
                    if (!w_green) begin
                        r_state <= (r_pend || w_arrival || w_level_req) ? PENDING : IDLE;
                        r_pend  <= 1'b0;
                    end else if (w_arrival) begin
                        r_pend <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_pend  <= 1'b0;
                end
            endcase
        end
    end

    assign C           = (r_state == PENDING);
    assign sensor_db   = w_db;
    assign veh_count   = r_veh;
    assign stuck_fault = w_stuck;

endmodule

`default_nettype wire
